bfly_seq_ctrl: RTL and testbench
================================

// Module: bfly_seq_ctrl
// PURPOSE
//   Sequencer for one radix-2 single-delay-feedback FFT stage built around bfly.
//   - Accepts complex samples from upstream and drives the stage delay-line shift/mux.
//   - Generates bfly_valid, twiddle ROM addresses and downstream valid/select strobes.
//   - Runs frames of 2*NUM_PAIR samples in three phases: FILL, BFLY, DRAIN.
// PARAMETERS
//   NUM_PAIR   16  butterfly pairs per frame; power of two, >=2
//   TW_AW      4   twiddle ROM address width
//   TW_STRIDE  1   twiddle index step per drain sample (stage decimation)
// PORTS
//   clk         in   1      clock; all logic on posedge
//   rst         in   1      synchronous reset, active-high
//   flush       in   1      sync abort; restart at FILL, count 0
//   in_valid    in   1      upstream sample valid
//   in_ready    out  1      sample accepted when in_valid & in_ready
//   dn_ready    in   1      downstream accepts a result issued this cycle (seen next cycle)
//   sr_shift    out  1      delay line advances one entry this cycle
//   sr_sel      out  1      delay-line write source: 0 = din, 1 = bfly diff
//   bfly_valid  out  1      butterfly operands valid this cycle (comb)
//   tw_addr     out  TW_AW  twiddle ROM address (comb)
//   tw_valid    out  1      tw_addr valid this cycle (comb)
//   out_valid   out  1      registered; result available downstream
//   out_sel     out  1      registered; 0 = sum path, 1 = twiddled diff path
//   frame_done  out  1      registered pulse, coincides with the last DRAIN out_valid
//   frame_cnt   out  16     completed frames, wraps at 2^16
//   busy        out  1      high unless state == FILL and cnt == 0
// BEHAVIOUR
//   Reset / flush
//   - Reset, or flush=1 at a clock edge: state=FILL, cnt=0, all registered outputs 0.
//   - Reset also clears frame_cnt to 0. Flush leaves frame_cnt unchanged.
//   - Reset and flush take effect mid-frame. Any in-flight out_valid is dropped.
//   - Reset has priority over flush. During a flush cycle all comb outputs are 0.
//   State machine (cnt runs 0..NUM_PAIR-1; every phase exit resets cnt to 0)
//   - FILL:  in_ready=1. On accept: sr_shift=1, sr_sel=0, cnt++.
//            Accept at cnt==NUM_PAIR-1 -> BFLY.
//   - BFLY:  in_ready=dn_ready. On accept: bfly_valid=1, sr_shift=1, sr_sel=1, cnt++.
//            Next cycle: out_valid=1, out_sel=0. Accept at cnt==NUM_PAIR-1 -> DRAIN.
//   - DRAIN: in_ready=0. When dn_ready=1: sr_shift=1, sr_sel=0, tw_valid=1,
//            tw_addr=(cnt*TW_STRIDE) mod 2^TW_AW, cnt++.
//            Next cycle: out_valid=1, out_sel=1.
//            Step at cnt==NUM_PAIR-1 -> FILL; next cycle frame_done=1 and frame_cnt+1.
//   Stall rules
//   - dn_ready=0 in BFLY or DRAIN: nothing advances. sr_shift, bfly_valid, tw_valid = 0.
//   - in_valid=0 in FILL or BFLY: no advance, no bubble entered into the delay line.
//   - There is no fill/drain overlap. Input is blocked for NUM_PAIR issue cycles per frame.
//   Timing and arithmetic
//   - Latency: issue -> out_valid is exactly 1 cycle, matching the registered bfly outputs.
//   - Counter and tw_addr arithmetic is unsigned and truncated to TW_AW bits; wrap is legal.
//   - sr_shift is a single-cycle strobe, never asserted twice for one sample.
// STRUCTURE
//   - Package fft_ctrl_pkg holds:
//     - typedef enum logic [1:0] {FILL, BFLY, DRAIN} ctrl_state_t
//     - localparams SR_SEL_DIN=1'b0, SR_SEL_DIFF=1'b1, OUT_SEL_SUM=1'b0, OUT_SEL_DIFF=1'b1
//   - One natural sub-module, bfly_seq_cnt: pair counter with enable, sync clear
//     and a terminal-count flag (cnt==NUM_PAIR-1).
//   - FSM, strobe decode and output registers stay in bfly_seq_ctrl.
// TESTING (NUM_PAIR=4, TW_AW=2, TW_STRIDE=1 unless stated)
//   1. Reset, then 8 back-to-back samples with dn_ready=1, then 4 idle cycles:
//      - sr_sel = 0,0,0,0,1,1,1,1,0,0,0,0; bfly_valid on samples 5-8.
//      - out_sel = 0x4 then 1x4; tw_addr = 0,1,2,3; frame_done once; frame_cnt=1.
//   2. dn_ready=0 for 3 cycles after the 2nd BFLY accept:
//      - in_ready=0, no sr_shift, cnt held at 2.
//      - Resume gives exactly 4 sum out_valids total.
//   3. in_valid toggling 1,0,1,0 in FILL: sr_shift only on valid cycles; BFLY entered after 4 accepts.
//   4. flush asserted at DRAIN cnt=1:
//      - Next cycle state=FILL, cnt=0, busy=0, out_valid=0.
//      - No frame_done; frame_cnt unchanged.
//   5. TW_STRIDE=3, TW_AW=2: DRAIN tw_addr = 0,3,2,1 (mod-4 wrap).
//   6. 65536 frames, or frame_cnt preloaded via force to 16'hFFFF, one more frame:
//      frame_cnt wraps to 0 and frame_done pulses.

Source files
------------

// File: rtl/bfly_seq_ctrl_pkg.sv
// Shared types and constants for the radix-2 SDF stage sequencer.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        BFLY  = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

    // Delay-line write source select
    localparam logic SR_SEL_DIN   = 1'b0;
    localparam logic SR_SEL_DIFF  = 1'b1;

    // Downstream result path select
    localparam logic OUT_SEL_SUM  = 1'b0;
    localparam logic OUT_SEL_DIFF = 1'b1;

endpackage

// File: rtl/bfly_seq_ctrl_if.sv
// Upstream/downstream handshake bundle of the SDF stage sequencer.
// master = sequencer side, slave = surrounding datapath/environment side.
interface bfly_seq_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic dn_ready;
    logic out_valid;
    logic out_sel;
    logic frame_done;

    modport master (
        input  in_valid,
        input  dn_ready,
        output in_ready,
        output out_valid,
        output out_sel,
        output frame_done
    );

    modport slave (
        output in_valid,
        output dn_ready,
        input  in_ready,
        input  out_valid,
        input  out_sel,
        input  frame_done
    );
endinterface

// File: rtl/bfly_seq_cnt.sv
// Pair counter: counts 0..NUM_PAIR-1 on enable, wraps to 0 after the
// terminal count, and flags the terminal count combinationally.
module bfly_seq_cnt #(
    parameter int NUM_PAIR = 16,
    parameter int CW       = $clog2(NUM_PAIR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);
    logic [CW-1:0] cnt_reg;

    assign cnt = cnt_reg;
    assign tc  = (cnt_reg == CW'(NUM_PAIR - 1));

    // Count one step per enabled cycle; terminal step returns to 0 so every phase starts at 0
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= tc ? '0 : cnt_reg + CW'(1);
        end
    end
endmodule

// File: rtl/bfly_seq_ctrl.sv
// Sequencer for one radix-2 single-delay-feedback FFT stage: FILL the delay
// line with the first half of a frame, run the butterflies on the second half
// (sum path out, diff path fed back), then DRAIN the twiddled diff path.
module bfly_seq_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int NUM_PAIR  = 16,
    parameter int TW_AW     = 4,
    parameter int TW_STRIDE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    bfly_seq_ctrl_if.master    bus,
    output logic               sr_shift,
    output logic               sr_sel,
    output logic               bfly_valid,
    output logic [TW_AW-1:0]   tw_addr,
    output logic               tw_valid,
    output logic [15:0]        frame_cnt,
    output logic               busy
);
    localparam int              CW       = $clog2(NUM_PAIR);
    localparam logic [TW_AW-1:0] STRIDE_T = TW_AW'(TW_STRIDE);

    ctrl_state_t    state_reg;
    logic [CW-1:0]  cnt;
    logic           cnt_tc;
    logic           out_valid_reg;
    logic           out_sel_reg;
    logic           frame_done_reg;
    logic [15:0]    frame_cnt_reg;

    logic           in_ready_c;
    logic           fill_acc;
    logic           bfly_acc;
    logic           drain_step;
    logic [TW_AW-1:0] tw_idx;

    // Decode this cycle's advance condition; reset and flush suppress every strobe
    always_comb begin
        in_ready_c = 1'b0;
        fill_acc   = 1'b0;
        bfly_acc   = 1'b0;
        drain_step = 1'b0;
        if (!rst && !flush) begin
            unique case (state_reg)
                FILL: begin
                    in_ready_c = 1'b1;
                    fill_acc   = bus.in_valid;
                end
                BFLY: begin
                    in_ready_c = bus.dn_ready;
                    bfly_acc   = bus.in_valid & bus.dn_ready;
                end
                DRAIN: begin
                    drain_step = bus.dn_ready;
                end
                default: ;
            endcase
        end
    end

    // Twiddle index: mod 2^TW_AW falls out of the TW_AW-wide multiply
    assign tw_idx     = TW_AW'(cnt) * STRIDE_T;

    assign sr_shift   = fill_acc | bfly_acc | drain_step;
    assign sr_sel     = bfly_acc ? SR_SEL_DIFF : SR_SEL_DIN;
    assign bfly_valid = bfly_acc;
    assign tw_valid   = drain_step;
    assign tw_addr    = drain_step ? tw_idx : '0;

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_sel    = out_sel_reg;
    assign bus.frame_done = frame_done_reg;
    assign frame_cnt      = frame_cnt_reg;
    assign busy           = !((state_reg == FILL) && (cnt == '0));

    bfly_seq_cnt #(
        .NUM_PAIR (NUM_PAIR),
        .CW       (CW)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .en  (sr_shift),
        .cnt (cnt),
        .tc  (cnt_tc)
    );

    // Phase FSM plus the one-cycle-late result strobes that line up with the registered bfly outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= FILL;
            out_valid_reg  <= 1'b0;
            out_sel_reg    <= OUT_SEL_SUM;
            frame_done_reg <= 1'b0;
            frame_cnt_reg  <= '0;
        end else if (flush) begin
            state_reg      <= FILL;
            out_valid_reg  <= 1'b0;
            out_sel_reg    <= OUT_SEL_SUM;
            frame_done_reg <= 1'b0;
        end else begin
            out_valid_reg  <= bfly_acc | drain_step;
            out_sel_reg    <= drain_step ? OUT_SEL_DIFF : OUT_SEL_SUM;
            frame_done_reg <= drain_step & cnt_tc;
            if (drain_step && cnt_tc) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
            unique case (state_reg)
                FILL:    if (fill_acc && cnt_tc)   state_reg <= BFLY;
                BFLY:    if (bfly_acc && cnt_tc)   state_reg <= DRAIN;
                DRAIN:   if (drain_step && cnt_tc) state_reg <= FILL;
                default: state_reg <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_bfly_seq_ctrl.sv
// Directed bench for bfly_seq_ctrl: NUM_PAIR=4, TW_AW=2; a second instance
// with TW_STRIDE=3 exercises twiddle address wrap.
module tb_bfly_seq_ctrl;
    import fft_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    bfly_seq_ctrl_if ifc ();
    bfly_seq_ctrl_if ifc2 ();

    logic       sr_shift, sr_sel, bfly_valid, tw_valid, busy;
    logic [1:0] tw_addr;
    logic [15:0] frame_cnt;
    logic       sr_shift_2, sr_sel_2, bfly_valid_2, tw_valid_2, busy_2;
    logic [1:0] tw_addr_2;
    logic [15:0] frame_cnt_2;

    int n_cmp = 0;
    int n_bad = 0;

    bfly_seq_ctrl #(.NUM_PAIR(4), .TW_AW(2), .TW_STRIDE(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(ifc),
        .sr_shift(sr_shift), .sr_sel(sr_sel), .bfly_valid(bfly_valid),
        .tw_addr(tw_addr), .tw_valid(tw_valid), .frame_cnt(frame_cnt), .busy(busy)
    );

    bfly_seq_ctrl #(.NUM_PAIR(4), .TW_AW(2), .TW_STRIDE(3)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .bus(ifc2),
        .sr_shift(sr_shift_2), .sr_sel(sr_sel_2), .bfly_valid(bfly_valid_2),
        .tw_addr(tw_addr_2), .tw_valid(tw_valid_2), .frame_cnt(frame_cnt_2), .busy(busy_2)
    );

    // Stimulus only: drive inputs after the falling edge, settle comb outputs
    task automatic cyc(input logic iv, input logic dr);
        @(negedge clk);
        ifc.in_valid = iv;
        ifc.dn_ready = dr;
        #1;
    endtask

    task automatic cyc2(input logic iv, input logic dr);
        @(negedge clk);
        ifc2.in_valid = iv;
        ifc2.dn_ready = dr;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        flush = 1'b0;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        n_cmp++; if (sr_shift !== 1'b0) begin n_bad++; $display("FAIL reset_sr_shift: got %b want 0", sr_shift); end
        n_cmp++; if (ifc.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", ifc.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        ifc.in_valid = 1'b0;
        #1;
        n_cmp++; if (ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
        n_cmp++; if (ifc.frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", ifc.frame_done); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (ifc.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_fill_in_ready: got %b want 1", ifc.in_ready); end
        n_cmp++; if (dut.state_reg !== FILL) begin n_bad++; $display("FAIL reset_state: got %0d want FILL", dut.state_reg); end
        $display("test_reset: done");
    endtask

    task automatic test_frame;
        logic e_ov, e_os, e_fd, e_bf;
        logic [1:0] e_tw;
        for (int i = 0; i < 13; i++) begin
            cyc(i < 8, 1'b1);
            if (i > 0) begin
                e_ov = (i - 1) >= 4;
                e_os = (i - 1) >= 8;
                e_fd = (i - 1) == 11;
                n_cmp++; if (ifc.out_valid !== e_ov) begin n_bad++; $display("FAIL frame_out_valid[%0d]: got %b want %b", i, ifc.out_valid, e_ov); end
                n_cmp++; if (ifc.out_sel !== e_os) begin n_bad++; $display("FAIL frame_out_sel[%0d]: got %b want %b", i, ifc.out_sel, e_os); end
                n_cmp++; if (ifc.frame_done !== e_fd) begin n_bad++; $display("FAIL frame_done[%0d]: got %b want %b", i, ifc.frame_done, e_fd); end
            end
            if (i < 12) begin
                e_bf = (i >= 4) && (i < 8);
                e_tw = (i >= 8) ? 2'(i - 8) : 2'd0;
                n_cmp++; if (sr_shift !== 1'b1) begin n_bad++; $display("FAIL frame_sr_shift[%0d]: got %b want 1", i, sr_shift); end
                n_cmp++; if (sr_sel !== e_bf) begin n_bad++; $display("FAIL frame_sr_sel[%0d]: got %b want %b", i, sr_sel, e_bf); end
                n_cmp++; if (bfly_valid !== e_bf) begin n_bad++; $display("FAIL frame_bfly_valid[%0d]: got %b want %b", i, bfly_valid, e_bf); end
                n_cmp++; if (tw_valid !== (i >= 8)) begin n_bad++; $display("FAIL frame_tw_valid[%0d]: got %b want %b", i, tw_valid, (i >= 8)); end
                n_cmp++; if (tw_addr !== e_tw) begin n_bad++; $display("FAIL frame_tw_addr[%0d]: got %0d want %0d", i, tw_addr, e_tw); end
                n_cmp++; if (ifc.in_ready !== (i < 8)) begin n_bad++; $display("FAIL frame_in_ready[%0d]: got %b want %b", i, ifc.in_ready, (i < 8)); end
            end
            $display("test_frame: cycle %0d sr_shift=%b sr_sel=%b bfly_valid=%b tw=%b/%0d out_valid=%b out_sel=%b frame_done=%b",
                     i, sr_shift, sr_sel, bfly_valid, tw_valid, tw_addr, ifc.out_valid, ifc.out_sel, ifc.frame_done);
        end
        n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL frame_cnt_after: got %0d want 1", frame_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL frame_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_stall;
        int sums = 0;
        int diffs = 0;
        int fds = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(i < 11, !(i >= 6 && i <= 8));
            if (i > 0) begin
                if (ifc.out_valid === 1'b1 && ifc.out_sel === 1'b0) sums++;
                if (ifc.out_valid === 1'b1 && ifc.out_sel === 1'b1) diffs++;
                if (ifc.frame_done === 1'b1) fds++;
            end
            if (i >= 6 && i <= 8) begin
                n_cmp++; if (ifc.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, ifc.in_ready); end
                n_cmp++; if (sr_shift !== 1'b0) begin n_bad++; $display("FAIL stall_sr_shift[%0d]: got %b want 0", i, sr_shift); end
                n_cmp++; if (bfly_valid !== 1'b0) begin n_bad++; $display("FAIL stall_bfly_valid[%0d]: got %b want 0", i, bfly_valid); end
                n_cmp++; if (dut.cnt !== 2'd2) begin n_bad++; $display("FAIL stall_cnt[%0d]: got %0d want 2", i, dut.cnt); end
                n_cmp++; if (dut.state_reg !== BFLY) begin n_bad++; $display("FAIL stall_state[%0d]: got %0d want BFLY", i, dut.state_reg); end
                n_cmp++; if (ifc.out_valid !== (i == 6)) begin n_bad++; $display("FAIL stall_out_valid[%0d]: got %b want %b", i, ifc.out_valid, (i == 6)); end
            end
        end
        n_cmp++; if (sums !== 4) begin n_bad++; $display("FAIL stall_sum_count: got %0d want 4", sums); end
        n_cmp++; if (diffs !== 4) begin n_bad++; $display("FAIL stall_diff_count: got %0d want 4", diffs); end
        n_cmp++; if (fds !== 1) begin n_bad++; $display("FAIL stall_frame_done_count: got %0d want 1", fds); end
        n_cmp++; if (frame_cnt !== 16'd2) begin n_bad++; $display("FAIL stall_frame_cnt: got %0d want 2", frame_cnt); end
        $display("test_stall: sums=%0d diffs=%0d frame_cnt=%0d", sums, diffs, frame_cnt);
    endtask

    task automatic test_fill_toggle;
        int fds = 0;
        for (int i = 0; i < 7; i++) begin
            cyc((i % 2) == 0, 1'b1);
            n_cmp++; if (sr_shift !== ((i % 2) == 0)) begin n_bad++; $display("FAIL toggle_sr_shift[%0d]: got %b want %b", i, sr_shift, ((i % 2) == 0)); end
            n_cmp++; if (sr_sel !== 1'b0) begin n_bad++; $display("FAIL toggle_sr_sel[%0d]: got %b want 0", i, sr_sel); end
        end
        cyc(1'b0, 1'b1);
        n_cmp++; if (dut.state_reg !== BFLY) begin n_bad++; $display("FAIL toggle_state: got %0d want BFLY", dut.state_reg); end
        n_cmp++; if (sr_shift !== 1'b0) begin n_bad++; $display("FAIL toggle_bfly_idle_shift: got %b want 0", sr_shift); end
        for (int i = 0; i < 9; i++) begin
            cyc(i < 4, 1'b1);
            if (ifc.frame_done === 1'b1) fds++;
        end
        n_cmp++; if (fds !== 1) begin n_bad++; $display("FAIL toggle_frame_done_count: got %0d want 1", fds); end
        n_cmp++; if (frame_cnt !== 16'd3) begin n_bad++; $display("FAIL toggle_frame_cnt: got %0d want 3", frame_cnt); end
        $display("test_fill_toggle: frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_flush;
        for (int i = 0; i < 9; i++) cyc(i < 8, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.dn_ready = 1'b1;
        #1;
        n_cmp++; if (dut.cnt !== 2'd1) begin n_bad++; $display("FAIL flush_pre_cnt: got %0d want 1", dut.cnt); end
        n_cmp++; if (sr_shift !== 1'b0) begin n_bad++; $display("FAIL flush_sr_shift: got %b want 0", sr_shift); end
        n_cmp++; if (tw_valid !== 1'b0) begin n_bad++; $display("FAIL flush_tw_valid: got %b want 0", tw_valid); end
        @(negedge clk);
        flush = 1'b0;
        ifc.in_valid = 1'b0;
        #1;
        n_cmp++; if (dut.state_reg !== FILL) begin n_bad++; $display("FAIL flush_state: got %0d want FILL", dut.state_reg); end
        n_cmp++; if (dut.cnt !== 2'd0) begin n_bad++; $display("FAIL flush_cnt: got %0d want 0", dut.cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b want 0", busy); end
        n_cmp++; if (ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b want 0", ifc.out_valid); end
        n_cmp++; if (ifc.frame_done !== 1'b0) begin n_bad++; $display("FAIL flush_frame_done: got %b want 0", ifc.frame_done); end
        cyc(1'b0, 1'b1);
        n_cmp++; if (ifc.frame_done !== 1'b0) begin n_bad++; $display("FAIL flush_frame_done_late: got %b want 0", ifc.frame_done); end
        n_cmp++; if (frame_cnt !== 16'd3) begin n_bad++; $display("FAIL flush_frame_cnt: got %0d want 3", frame_cnt); end
        $display("test_flush: frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_stride;
        logic [1:0] exp_tw [4];
        exp_tw = '{2'd0, 2'd3, 2'd2, 2'd1};
        for (int i = 0; i < 13; i++) begin
            cyc2(i < 8, 1'b1);
            if (i >= 8 && i < 12) begin
                n_cmp++; if (tw_addr_2 !== exp_tw[i - 8]) begin n_bad++; $display("FAIL stride_tw_addr[%0d]: got %0d want %0d", i - 8, tw_addr_2, exp_tw[i - 8]); end
                n_cmp++; if (tw_valid_2 !== 1'b1) begin n_bad++; $display("FAIL stride_tw_valid[%0d]: got %b want 1", i - 8, tw_valid_2); end
            end
        end
        n_cmp++; if (ifc2.frame_done !== 1'b1) begin n_bad++; $display("FAIL stride_frame_done: got %b want 1", ifc2.frame_done); end
        $display("test_stride: frame_cnt_2=%0d", frame_cnt_2);
    endtask

    task automatic test_wrap;
        @(negedge clk);
        force dut.frame_cnt_reg = 16'hFFFF;
        #1;
        release dut.frame_cnt_reg;
        for (int i = 0; i < 13; i++) begin
            cyc(i < 8, 1'b1);
            if (i == 12) begin
                n_cmp++; if (ifc.frame_done !== 1'b1) begin n_bad++; $display("FAIL wrap_frame_done: got %b want 1", ifc.frame_done); end
            end
            if (i == 11) begin
                n_cmp++; if (frame_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_frame_cnt_pre: got %h want ffff", frame_cnt); end
            end
        end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL wrap_frame_cnt: got %h want 0000", frame_cnt); end
        $display("test_wrap: frame_cnt=%h", frame_cnt);
    endtask

    task automatic test_midframe_reset;
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (sr_shift !== 1'b0) begin n_bad++; $display("FAIL midrst_sr_shift: got %b want 0", sr_shift); end
        @(negedge clk);
        rst = 1'b0;
        ifc.in_valid = 1'b0;
        #1;
        n_cmp++; if (dut.state_reg !== FILL) begin n_bad++; $display("FAIL midrst_state: got %0d want FILL", dut.state_reg); end
        n_cmp++; if (dut.cnt !== 2'd0) begin n_bad++; $display("FAIL midrst_cnt: got %0d want 0", dut.cnt); end
        n_cmp++; if (ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", ifc.out_valid); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst_frame_cnt: got %0d want 0", frame_cnt); end
        $display("test_midframe_reset: done");
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.dn_ready = 1'b0;
        ifc2.in_valid = 1'b0;
        ifc2.dn_ready = 1'b0;
        test_reset();
        test_frame();
        test_stall();
        test_fill_toggle();
        test_flush();
        test_stride();
        test_wrap();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
